// File: rtl/seq_operator_unit.sv
// Clocked operator engine: valid/ready request in, registered result out; DIV/MOD via iterative restoring divider.
// Optional macro SIGNED_OPS_EN adds the signed_mode port for two's-complement arithmetic.
module seq_operator_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
`ifdef SIGNED_OPS_EN
    ,
    input  logic                 signed_mode
`endif
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_MUL  = 4'd0;
    localparam logic [3:0] OP_DIV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_LNOT = 4'd5;
    localparam logic [3:0] OP_LAND = 4'd6;
    localparam logic [3:0] OP_LOR  = 4'd7;
    localparam logic [3:0] OP_LT   = 4'd8;
    localparam logic [3:0] OP_GT   = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_BNOT = 4'd11;
    localparam logic [3:0] OP_XRED = 4'd12;
    localparam logic [3:0] OP_SEL  = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [RW-1:0]      r_result;
    logic               r_err;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_is_mod;
    logic               r_sgn;
    logic               r_qneg;
    logic               r_rneg;

    logic               w_sgn;
    logic               w_accept;
    logic               w_is_divop;
    logic [RW-1:0]      w_ax;
    logic [RW-1:0]      w_bx;
    logic               w_lt;
    logic               w_gt;
    logic [RW-1:0]      w_res;
    logic               w_err;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_qval;
    logic [WIDTH-1:0]   w_rval;
    logic [WIDTH-1:0]   w_fin;
    logic [RW-1:0]      w_fin_ext;

`ifdef SIGNED_OPS_EN
    assign w_sgn = signed_mode;
`else
    assign w_sgn = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign err       = r_err;

    assign w_accept   = in_valid && r_in_ready;
    assign w_is_divop = ((op == OP_DIV) || (op == OP_MOD)) && (b != '0);

    // Extended operands: low 2*WIDTH bits of add/sub/mul are then correct for both signed and unsigned.
    assign w_ax = w_sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_bx = w_sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign w_lt = w_sgn ? ($signed(a) < $signed(b)) : (a < b);
    assign w_gt = w_sgn ? ($signed(a) > $signed(b)) : (a > b);

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (op)
            OP_MUL:  w_res = w_ax * w_bx;
            OP_DIV:  begin
                w_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                w_err = 1'b1;
            end
            OP_ADD:  w_res = w_ax + w_bx;
            OP_SUB:  w_res = w_ax - w_bx;
            OP_MOD:  begin
                w_res = w_ax;
                w_err = 1'b1;
            end
            OP_LNOT: w_res[0] = (a == '0);
            OP_LAND: w_res[0] = (a != '0) && (b != '0);
            OP_LOR:  w_res[0] = (a != '0) || (b != '0);
            OP_LT:   w_res[0] = w_lt;
            OP_GT:   w_res[0] = w_gt;
            OP_EQ:   w_res[0] = (a == b);
            OP_BNOT: w_res = {{WIDTH{1'b0}}, ~b};
            OP_XRED: w_res[0] = ^b;
            OP_SEL:  w_res = (a != '0) ? RW'(1) : RW'(2);
            default: w_err = 1'b1;
        endcase
    end

    // Divider works on magnitudes; signs are reapplied on the final iteration.
    assign w_amag = (w_sgn && a[WIDTH-1]) ? -a : a;
    assign w_bmag = (w_sgn && b[WIDTH-1]) ? -b : b;

    assign w_trial    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_trial >= {1'b0, r_b});
    assign w_rem_next = w_ge ? (w_trial[WIDTH-1:0] - r_b) : w_trial[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    assign w_qval    = r_qneg ? -w_quo_next : w_quo_next;
    assign w_rval    = r_rneg ? -w_rem_next : w_rem_next;
    assign w_fin     = r_is_mod ? w_rval : w_qval;
    assign w_fin_ext = r_sgn ? {{WIDTH{w_fin[WIDTH-1]}}, w_fin} : {{WIDTH{1'b0}}, w_fin};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_is_mod    <= 1'b0;
            r_sgn       <= 1'b0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_is_divop) begin
                            r_state  <= S_DIV;
                            r_rem    <= '0;
                            r_quo    <= w_amag;
                            r_b      <= w_bmag;
                            r_cnt    <= '0;
                            r_is_mod <= (op == OP_MOD);
                            r_sgn    <= w_sgn;
                            r_qneg   <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_rneg   <= w_sgn && a[WIDTH-1];
                        end else begin
                            r_state     <= S_DONE;
                            r_result    <= w_res;
                            r_err       <= w_err;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state     <= S_DONE;
                        r_result    <= w_fin_ext;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
